// File: rtl/twf_pkg.sv
// Shared types and elaboration-time helpers for the twiddle-factor generator.
package twf_pkg;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} sweep_state_e;

  localparam real PI = 3.14159265358979323846;

  // round(2^frac * cos(2*pi*a/n_fft)), half away from zero; only evaluated at elaboration.
  function automatic int cos_fixed(input int a, input int n_fft, input int frac);
    real v;
    v = $cos(2.0 * PI * real'(a) / real'(n_fft)) * (2.0 ** frac);
    if (v >= 0.0) return int'($floor(v + 0.5));
    return -int'($floor(0.5 - v));
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r = r | (((v >> i) & 32'd1) << (w - 1 - i));
    return r;
  endfunction

endpackage

// File: rtl/twf_quarter_rom.sv
// Quarter-wave cosine table, C[a] for a = 0..N_FFT/4, with two combinational read ports.
module twf_quarter_rom
  import twf_pkg::*;
#(
  parameter  int N_FFT     = 64,
  parameter  int BIT_WIDTH = 9,
  parameter  int FRAC      = 7,
  localparam int AW        = $clog2(N_FFT) - 1
) (
  input  logic        [AW-1:0]        addr_a,
  input  logic        [AW-1:0]        addr_b,
  output logic signed [BIT_WIDTH-1:0] data_a,
  output logic signed [BIT_WIDTH-1:0] data_b
);

  localparam int DEPTH = N_FFT / 4 + 1;

  logic signed [BIT_WIDTH-1:0] rom [DEPTH];

  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    localparam int VAL = cos_fixed(a, N_FFT, FRAC);
    assign rom[a] = BIT_WIDTH'(VAL);
  end

  assign data_a = rom[addr_a];
  assign data_b = rom[addr_b];

endmodule

// File: rtl/twf_gen.sv
// Pipelined twiddle generator: index decode -> quadrant fold over a quarter-wave ROM,
// with random-access lookup and an autonomous full-frame sweep.
module twf_gen
  import twf_pkg::*;
#(
  parameter int N_FFT     = 64,
  parameter int M_BITS    = 3,
  parameter int N_BITS    = 3,
  parameter int IDX_W     = 9,
  parameter int BIT_WIDTH = 9,
  parameter int FRAC      = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mode,
  input  logic                        in_valid,
  input  logic        [IDX_W-1:0]     in_index,
  input  logic                        start,
  input  logic                        stall,
  output logic                        busy,
  output logic                        done,
  output logic                        out_valid,
  output logic        [IDX_W-1:0]     out_index,
  output logic signed [BIT_WIDTH-1:0] twf_re,
  output logic signed [BIT_WIDTH-1:0] twf_im
);

  localparam int KW = $clog2(N_FFT);
  localparam int AW = KW - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  sweep_state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;

  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [IDX_W-1:0] s1_index_q, s1_index_d;
  quad_e s1_quad_q, s1_quad_d;
  logic [AW-1:0] s1_addr_a_q, s1_addr_a_d, s1_addr_b_q, s1_addr_b_d;

  logic out_valid_q, out_valid_d, done_q, done_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic signed [BIT_WIDTH-1:0] twf_re_q, twf_re_d, twf_im_q, twf_im_d;

  logic issue_sweep, issue_lookup;
  logic [M_BITS-1:0] m_field;
  logic [N_BITS-1:0] n_field;
  logic [KW-1:0] k;
  logic signed [BIT_WIDTH-1:0] rom_a, rom_b;

  twf_quarter_rom #(
    .N_FFT    (N_FFT),
    .BIT_WIDTH(BIT_WIDTH),
    .FRAC     (FRAC)
  ) u_rom (
    .addr_a(s1_addr_a_q),
    .addr_b(s1_addr_b_q),
    .data_a(rom_a),
    .data_b(rom_b)
  );

  always_comb begin
    issue_sweep  = (state_q == S_RUN);
    issue_lookup = !mode && in_valid && (state_q == S_IDLE);

    s1_valid_d  = issue_sweep || issue_lookup;
    s1_index_d  = issue_sweep ? cnt_q : in_index;
    s1_last_d   = issue_sweep && (cnt_q == LAST_IDX);
    m_field     = s1_index_d[N_BITS+M_BITS-1:N_BITS];
    n_field     = s1_index_d[N_BITS-1:0];
    k           = KW'(bitrev(32'(m_field), M_BITS) * 32'(n_field));
    s1_quad_d   = quad_e'(k[KW-1 -: 2]);
    s1_addr_a_d = AW'(k[KW-3:0]);
    s1_addr_b_d = AW'(N_FFT / 4) - AW'(k[KW-3:0]);

    // rom_a = C[r], rom_b = C[N/4-r]; each quadrant picks, swaps and negates them.
    twf_re_d = twf_re_q;
    twf_im_d = twf_im_q;
    if (s1_valid_q) begin
      case (s1_quad_q)
        Q0:      begin twf_re_d =  rom_a; twf_im_d = -rom_b; end
        Q1:      begin twf_re_d = -rom_b; twf_im_d = -rom_a; end
        Q2:      begin twf_re_d = -rom_a; twf_im_d =  rom_b; end
        default: begin twf_re_d =  rom_b; twf_im_d =  rom_a; end
      endcase
    end
    out_valid_d = s1_valid_q;
    out_index_d = s1_valid_q ? s1_index_q : out_index_q;
    done_d      = s1_valid_q && s1_last_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: if (mode && start) begin
        state_d = S_RUN;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      S_RUN: begin
        if (cnt_q == LAST_IDX) state_d = S_FLUSH;
        else                   cnt_d   = cnt_q + IDX_W'(1);
      end
      S_FLUSH: if (done_q) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: stall is a clock enable for every flop; reset takes priority so it can abort a stalled sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_index_q  <= '0;
      s1_quad_q   <= Q0;
      s1_addr_a_q <= '0;
      s1_addr_b_q <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_index_q <= '0;
      twf_re_q    <= '0;
      twf_im_q    <= '0;
    end else if (!stall) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_index_q  <= s1_index_d;
      s1_quad_q   <= s1_quad_d;
      s1_addr_a_q <= s1_addr_a_d;
      s1_addr_b_q <= s1_addr_b_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      out_index_q <= out_index_d;
      twf_re_q    <= twf_re_d;
      twf_im_q    <= twf_im_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign twf_re    = twf_re_q;
  assign twf_im    = twf_im_q;

endmodule

// File: tb/tb_twf_gen.sv
// Self-checking bench for twf_gen: directed lookups, stalled streams, random traffic,
// full sweeps, reset abort and a small-N parameter set, against a direct cos/sin model.
module tb_twf_gen;

  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int idx;
    int due;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, mode = 1'b0, in_valid = 1'b0, start = 1'b0, stall = 1'b0;
  logic [8:0] in_index = '0;
  logic busy, done, out_valid;
  logic [8:0] out_index;
  logic signed [8:0] twf_re, twf_im;

  logic mode16 = 1'b0, in_valid16 = 1'b0, start16 = 1'b0, stall16 = 1'b0;
  logic [4:0] in_index16 = '0;
  logic busy16, done16, out_valid16;
  logic [4:0] out_index16;
  logic signed [11:0] re16, im16;

  int checks = 0;
  int failures = 0;

  twf_gen #(.N_FFT(64), .M_BITS(3), .N_BITS(3), .IDX_W(9), .BIT_WIDTH(9), .FRAC(7)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_index(in_index),
    .start(start), .stall(stall), .busy(busy), .done(done), .out_valid(out_valid),
    .out_index(out_index), .twf_re(twf_re), .twf_im(twf_im)
  );

  twf_gen #(.N_FFT(16), .M_BITS(2), .N_BITS(2), .IDX_W(5), .BIT_WIDTH(12), .FRAC(10)) dut16 (
    .clk(clk), .rst(rst), .mode(mode16), .in_valid(in_valid16), .in_index(in_index16),
    .start(start16), .stall(stall16), .busy(busy16), .done(done16), .out_valid(out_valid16),
    .out_index(out_index16), .twf_re(re16), .twf_im(im16)
  );

  // Reference: W_N^k straight from cos/sin with k = bitrev(m)*n mod N.
  function automatic int ref_tw(input int idx, input int nfft, input int mb, input int nb,
                                input int frac, input bit im);
    int m, n, br, k;
    real th, v;
    m  = (idx >> nb) % (1 << mb);
    n  = idx % (1 << nb);
    br = 0;
    for (int i = 0; i < mb; i++) if (((m >> i) & 1) == 1) br += 1 << (mb - 1 - i);
    k  = (br * n) % nfft;
    th = 2.0 * PI * real'(k) / real'(nfft);
    v  = (im ? -$sin(th) : $cos(th)) * (2.0 ** frac);
    return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(0.5 - v));
  endfunction

  function automatic int ref64(input int idx, input bit im);
    return ref_tw(idx, 64, 3, 3, 7, im);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: valid=%b busy=%b done=%b, required 0 0 0", out_valid, busy, done);
    end
    checks++;
    if (twf_re !== 9'sd0 || twf_im !== 9'sd0 || out_index !== 9'd0) begin
      failures++;
      $display("FAIL reset_data: re=%0d im=%0d idx=%0d, required 0 0 0", twf_re, twf_im, out_index);
    end
    checks++;
    if (out_valid16 !== 1'b0 || busy16 !== 1'b0 || re16 !== 12'sd0) begin
      failures++;
      $display("FAIL reset_n16: valid=%b busy=%b re=%0d, required 0 0 0", out_valid16, busy16, re16);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lookup_directed();
    int d_idx[6] = '{0, 9, 12, 33, 63, 264};
    int d_re[6]  = '{128, 118, 0, 127, 13, 128};
    int d_im[6]  = '{0, -49, -128, -13, 127, 0};
    mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_index = 9'(d_idx[i]);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL lookup_latency idx=%0d: valid=%b after 1 cycle, required 0", d_idx[i], out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_index !== 9'(d_idx[i]) ||
          twf_re !== 9'(d_re[i]) || twf_im !== 9'(d_im[i])) begin
        failures++;
        $display("FAIL lookup idx=%0d: valid=%b idx=%0d re=%0d im=%0d, required 1 %0d %0d %0d",
                 d_idx[i], out_valid, out_index, twf_re, twf_im, d_idx[i], d_re[i], d_im[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    req_t exp_q[$];
    req_t r;
    int nsc = 0, sent = 0, got = 0;
    logic p_ov;
    logic [8:0] p_idx;
    logic signed [8:0] p_re, p_im;
    p_ov = out_valid; p_idx = out_index; p_re = twf_re; p_im = twf_im;
    mode = 1'b0;
    for (int c = 0; c < 16; c++) begin
      stall    = (c >= 4 && c <= 6);
      in_valid = (sent < 8) || stall;
      in_index = stall ? 9'd511 : 9'(8 + sent);
      if (in_valid && !stall) begin
        exp_q.push_back('{8 + sent, nsc + 2});
        sent++;
      end
      tick();
      if (stall) begin
        checks++;
        if (out_valid !== p_ov || out_index !== p_idx || twf_re !== p_re || twf_im !== p_im) begin
          failures++;
          $display("FAIL b2b_frozen c=%0d: v=%b idx=%0d re=%0d im=%0d, held v=%b idx=%0d re=%0d im=%0d",
                   c, out_valid, out_index, twf_re, twf_im, p_ov, p_idx, p_re, p_im);
        end
      end else begin
        nsc++;
        checks++;
        if (exp_q.size() != 0 && exp_q[0].due == nsc) begin
          r = exp_q.pop_front();
          got++;
          if (out_valid !== 1'b1 || out_index !== 9'(r.idx) ||
              twf_re !== 9'(ref64(r.idx, 0)) || twf_im !== 9'(ref64(r.idx, 1))) begin
            failures++;
            $display("FAIL b2b_out c=%0d: v=%b idx=%0d re=%0d im=%0d, required 1 %0d %0d %0d",
                     c, out_valid, out_index, twf_re, twf_im, r.idx, ref64(r.idx, 0), ref64(r.idx, 1));
          end
        end else if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL b2b_spurious c=%0d: valid=%b idx=%0d, required 0", c, out_valid, out_index);
        end
      end
      p_ov = out_valid; p_idx = out_index; p_re = twf_re; p_im = twf_im;
    end
    in_valid = 1'b0;
    stall = 1'b0;
    checks++;
    if (got != 8 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: got %0d outputs with %0d pending, required 8 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_random_lookup();
    req_t exp_q[$];
    req_t r;
    int nsc = 0;
    int busy_bad = 0;
    logic p_ov;
    logic [8:0] p_idx;
    logic signed [8:0] p_re, p_im;
    p_ov = out_valid; p_idx = out_index; p_re = twf_re; p_im = twf_im;
    mode = 1'b0;
    for (int c = 0; c < 304; c++) begin
      stall    = (c < 300) && ($urandom_range(0, 4) == 0);
      in_valid = (c < 300) && ($urandom_range(0, 1) == 1);
      in_index = 9'($urandom);
      start    = (c < 300) && ($urandom_range(0, 7) == 0);
      if (in_valid && !stall) exp_q.push_back('{int'(in_index), nsc + 2});
      tick();
      if (busy !== 1'b0) busy_bad++;
      if (stall) begin
        checks++;
        if (out_valid !== p_ov || out_index !== p_idx || twf_re !== p_re || twf_im !== p_im) begin
          failures++;
          $display("FAIL rand_frozen c=%0d: v=%b idx=%0d re=%0d im=%0d, held v=%b idx=%0d re=%0d im=%0d",
                   c, out_valid, out_index, twf_re, twf_im, p_ov, p_idx, p_re, p_im);
        end
      end else begin
        nsc++;
        checks++;
        if (exp_q.size() != 0 && exp_q[0].due == nsc) begin
          r = exp_q.pop_front();
          if (out_valid !== 1'b1 || out_index !== 9'(r.idx) ||
              twf_re !== 9'(ref64(r.idx, 0)) || twf_im !== 9'(ref64(r.idx, 1))) begin
            failures++;
            $display("FAIL rand_out c=%0d: v=%b idx=%0d re=%0d im=%0d, required 1 %0d %0d %0d",
                     c, out_valid, out_index, twf_re, twf_im, r.idx, ref64(r.idx, 0), ref64(r.idx, 1));
          end
        end else if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL rand_spurious c=%0d: valid=%b idx=%0d, required 0", c, out_valid, out_index);
        end
      end
      p_ov = out_valid; p_idx = out_index; p_re = twf_re; p_im = twf_im;
    end
    in_valid = 1'b0;
    stall = 1'b0;
    start = 1'b0;
    checks++;
    if (busy_bad != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_tail: busy seen %0d times, %0d pending, required 0 and 0", busy_bad, exp_q.size());
    end
  endtask

  task automatic test_sweep();
    int next_exp = 0, done_cnt = 0;
    bit done_seen = 0, finished = 0;
    logic p_ov, p_done;
    logic [8:0] p_idx;
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL sweep_busy_start: busy=%b, required 1", busy);
    end
    p_ov = out_valid; p_done = done; p_idx = out_index;
    for (int c = 0; c < 1500 && !finished; c++) begin
      stall    = !done_seen && ($urandom_range(0, 7) == 0);
      start    = !done_seen && ($urandom_range(0, 5) == 0);
      in_valid = !done_seen && ($urandom_range(0, 1) == 1);
      mode     = done_seen ? 1'b0 : 1'($urandom);
      in_index = 9'($urandom);
      tick();
      if (stall) begin
        checks++;
        if (out_valid !== p_ov || done !== p_done || out_index !== p_idx) begin
          failures++;
          $display("FAIL sweep_frozen c=%0d: v=%b done=%b idx=%0d, held v=%b done=%b idx=%0d",
                   c, out_valid, done, out_index, p_ov, p_done, p_idx);
        end
      end else if (done_seen) begin
        finished = 1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL sweep_end: busy=%b done=%b valid=%b, required 0 0 0", busy, done, out_valid);
        end
      end else begin
        if (out_valid === 1'b1) begin
          checks++;
          if (out_index !== 9'(next_exp) || twf_re !== 9'(ref64(next_exp, 0)) ||
              twf_im !== 9'(ref64(next_exp, 1))) begin
            failures++;
            $display("FAIL sweep_out n=%0d: idx=%0d re=%0d im=%0d, required %0d %0d %0d",
                     next_exp, out_index, twf_re, twf_im, next_exp, ref64(next_exp, 0), ref64(next_exp, 1));
          end
          next_exp++;
        end
        if (done === 1'b1) begin
          done_cnt++;
          done_seen = 1;
          checks++;
          if (out_valid !== 1'b1 || out_index !== 9'd511 || busy !== 1'b1) begin
            failures++;
            $display("FAIL sweep_done: valid=%b idx=%0d busy=%b, required 1 511 1", out_valid, out_index, busy);
          end
        end
      end
      p_ov = out_valid; p_done = done; p_idx = out_index;
    end
    stall = 1'b0; start = 1'b0; in_valid = 1'b0; mode = 1'b0;
    checks++;
    if (next_exp != 512 || done_cnt != 1 || !finished) begin
      failures++;
      $display("FAIL sweep_count: outputs=%0d dones=%0d finished=%0d, required 512 1 1",
               next_exp, done_cnt, finished);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit hit = 0;
    int bad = 0;
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      tick();
      if (out_valid === 1'b1 && out_index === 9'd100) hit = 1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL abort_reach100: index 100 not seen within budget, required seen");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        twf_re !== 9'sd0 || twf_im !== 9'sd0 || out_index !== 9'd0) begin
      failures++;
      $display("FAIL abort_reset: v=%b busy=%b done=%b re=%0d im=%0d idx=%0d, required all 0",
               out_valid, busy, done, twf_re, twf_im, out_index);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_quiet: %0d cycles with activity after reset, required 0", bad);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      tick();
      if (out_valid === 1'b1) hit = 1;
    end
    checks++;
    if (!hit || out_index !== 9'd0 || twf_re !== 9'(ref64(0, 0)) || twf_im !== 9'(ref64(0, 1))) begin
      failures++;
      $display("FAIL abort_restart: seen=%0d idx=%0d re=%0d im=%0d, required 1 0 %0d %0d",
               hit, out_index, twf_re, twf_im, ref64(0, 0), ref64(0, 1));
    end
    mode = 1'b0;
  endtask

  task automatic test_param_n16();
    req_t exp_q[$];
    req_t r;
    int nsc = 0, got = 0;
    for (int c = 0; c < 35; c++) begin
      in_valid16 = (c < 32);
      in_index16 = 5'(c);
      if (in_valid16) exp_q.push_back('{c, nsc + 2});
      tick();
      nsc++;
      if (exp_q.size() != 0 && exp_q[0].due == nsc) begin
        r = exp_q.pop_front();
        got++;
        checks++;
        if (out_valid16 !== 1'b1 || out_index16 !== 5'(r.idx) ||
            re16 !== 12'(ref_tw(r.idx, 16, 2, 2, 10, 0)) ||
            im16 !== 12'(ref_tw(r.idx, 16, 2, 2, 10, 1))) begin
          failures++;
          $display("FAIL n16_out idx=%0d: v=%b idx=%0d re=%0d im=%0d, required 1 %0d %0d %0d",
                   r.idx, out_valid16, out_index16, re16, im16, r.idx,
                   ref_tw(r.idx, 16, 2, 2, 10, 0), ref_tw(r.idx, 16, 2, 2, 10, 1));
        end
      end
    end
    in_valid16 = 1'b0;
    checks++;
    if (got != 32) begin
      failures++;
      $display("FAIL n16_count: got %0d outputs, required 32", got);
    end
  endtask

  initial begin
    test_reset();
    test_lookup_directed();
    test_back_to_back();
    test_random_lookup();
    test_sweep();
    test_reset_mid_sweep();
    test_param_n16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
